// File: rtl/dco_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dco_pkg
// Purpose  : Shared constants and the increment-target helper for the
//            CDR digitally controlled oscillator (dco_nco).
// Contents : c_* default constants, calc_inc() clamped increment function.
// Revision : 1.0 - initial release
// ============================================================================
package dco_pkg;

    localparam int c_ACC_W       = 16;    // phase accumulator width
    localparam int c_CTRL_W      = 8;     // speed control word width
    localparam int c_CTRL_CENTER = 128;   // control value for nominal rate
    localparam int c_BASE_INC    = 4096;  // increment at centre (16 clk period)
    localparam int c_GAIN_SHIFT  = 2;     // loop gain as a left shift
    localparam int c_INC_MIN     = 2048;  // slowest allowed increment
    localparam int c_INC_MAX     = 8192;  // fastest allowed increment
    localparam int c_PCNT_W      = 8;     // period meter width

    // Clamped increment target. Evaluated in 32-bit signed arithmetic, which
    // is wider than the ACC_W+2 bits the offset needs, so no result is lost
    // before the clamp for any legal parameter set.
    function automatic int calc_inc(
        input int speed,
        input int center,
        input int base,
        input int shift,
        input int lo,
        input int hi
    );
        int t;
        int v;
        t = speed - center;
        v = base + (t <<< shift);
        if (v < lo) begin
            v = lo;
        end else if (v > hi) begin
            v = hi;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dco_nco_if.sv
`default_nettype none
// ============================================================================
// Module   : dco_nco_if
// Purpose  : Control/status bundle between the loop filter side and the DCO.
// Signals  : en, hold, speed_var            (controller -> DCO)
//            phase, rclk_out, sample_stb,
//            mid_stb, inc_active,
//            period_cnt, period_valid       (DCO -> consumers)
// Modports : master = controller/observer side, slave = DCO side.
// Revision : 1.0 - initial release
// ============================================================================
interface dco_nco_if
    import dco_pkg::*;
#(
    parameter int ACC_W  = c_ACC_W,
    parameter int CTRL_W = c_CTRL_W
);

    logic                en;
    logic                hold;
    logic [CTRL_W-1:0]   speed_var;
    logic [ACC_W-1:0]    phase;
    logic                rclk_out;
    logic                sample_stb;
    logic                mid_stb;
    logic [ACC_W-1:0]    inc_active;
    logic [c_PCNT_W-1:0] period_cnt;
    logic                period_valid;

    modport master (
        output en, hold, speed_var,
        input  phase, rclk_out, sample_stb, mid_stb,
        input  inc_active, period_cnt, period_valid
    );

    modport slave (
        input  en, hold, speed_var,
        output phase, rclk_out, sample_stb, mid_stb,
        output inc_active, period_cnt, period_valid
    );

endinterface
`default_nettype wire

// File: rtl/dco_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : dco_period_meter
// Purpose  : Measures the length, in enabled clock cycles, of each completed
//            DCO period. Saturates at the counter maximum.
// Ports    : clk, rst_n       clock / async active-low reset
//            en               accumulator advance enable (only these count)
//            wrap             accumulator wrap on this edge
//            period_cnt       length of the last completed period
//            period_valid     at least one period completed since reset
// Revision : 1.0 - initial release
// ============================================================================
module dco_period_meter
    import dco_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                en,
    input  wire logic                wrap,
    output logic [c_PCNT_W-1:0]      period_cnt,
    output logic                     period_valid
);

    localparam logic [c_PCNT_W-1:0] c_CNT_MAX = '1;

    logic [c_PCNT_W-1:0] r_cnt;
    logic [c_PCNT_W-1:0] r_period_cnt;
    logic                r_period_valid;
    logic [c_PCNT_W-1:0] w_cnt_inc;

    // The wrapping edge itself belongs to the period that is ending, so the
    // reported length is the running count plus one.
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_period_cnt   <= '0;
            r_period_valid <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                r_period_cnt   <= w_cnt_inc;
                r_cnt          <= '0;
                r_period_valid <= 1'b1;
            end else begin
                r_cnt          <= w_cnt_inc;
            end
        end
    end

    assign period_cnt   = r_period_cnt;
    assign period_valid = r_period_valid;

endmodule
`default_nettype wire

// File: rtl/dco_nco.sv
`default_nettype none
// ============================================================================
// Module   : dco_nco
// Purpose  : Phase-accumulator DCO driven by the CDR loop filter. Produces the
//            recovered clock, a per-period sample strobe and a mid-period
//            edge strobe. The speed word only takes effect at a wrap, so each
//            period runs at a single rate and rclk_out never glitches.
// Ports    : clk, rst_n       clock / async active-low reset
//            bus (slave)      en, hold, speed_var in;
//                             phase, rclk_out, sample_stb, mid_stb,
//                             inc_active, period_cnt, period_valid out
// Revision : 1.0 - initial release
// ============================================================================
module dco_nco
    import dco_pkg::*;
#(
    parameter int ACC_W       = c_ACC_W,
    parameter int CTRL_W      = c_CTRL_W,
    parameter int CTRL_CENTER = c_CTRL_CENTER,
    parameter int BASE_INC    = c_BASE_INC,
    parameter int GAIN_SHIFT  = c_GAIN_SHIFT,
    parameter int INC_MIN     = c_INC_MIN,
    parameter int INC_MAX     = c_INC_MAX
)(
    input  wire logic    clk,
    input  wire logic    rst_n,
    dco_nco_if.slave     bus
);

    logic [ACC_W-1:0]    r_phase;
    logic [ACC_W-1:0]    r_inc;
    logic                r_sample;
    logic                r_mid;

    logic [ACC_W:0]      w_sum;
    logic                w_wrap;
    logic                w_mid;
    logic [31:0]         w_speed;
    logic [ACC_W-1:0]    w_new_inc;
    logic [c_PCNT_W-1:0] w_period_cnt;
    logic                w_period_valid;

    // Carry-out of the accumulator marks the period boundary; the remainder
    // stays in r_phase so long-run frequency is exact.
    assign w_sum  = {1'b0, r_phase} + {1'b0, r_inc};
    assign w_wrap = w_sum[ACC_W];

    // Rising edge of the recovered clock. A step that both crosses the
    // midpoint and wraps is reported as a wrap only.
    assign w_mid  = ~r_phase[ACC_W-1] & w_sum[ACC_W-1] & ~w_wrap;

    assign w_speed   = 32'(bus.speed_var);
    assign w_new_inc = ACC_W'(calc_inc(int'(w_speed), CTRL_CENTER, BASE_INC,
                                       GAIN_SHIFT, INC_MIN, INC_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= '0;
            r_inc    <= ACC_W'(BASE_INC);
            r_sample <= 1'b0;
            r_mid    <= 1'b0;
        end else if (bus.en) begin
            r_phase  <= w_sum[ACC_W-1:0];
            r_sample <= w_wrap;
            r_mid    <= w_mid;
            // speed_var is only looked at on the wrapping edge; hold lets
            // the loop freeze the rate across a boundary.
            if (w_wrap && !bus.hold) begin
                r_inc <= w_new_inc;
            end
        end else begin
            r_sample <= 1'b0;
            r_mid    <= 1'b0;
        end
    end

    dco_period_meter u_period_meter (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (bus.en),
        .wrap         (w_wrap),
        .period_cnt   (w_period_cnt),
        .period_valid (w_period_valid)
    );

    assign bus.phase        = r_phase;
    // Taken straight from a flop bit, so it is glitch-free.
    assign bus.rclk_out     = r_phase[ACC_W-1];
    assign bus.sample_stb   = r_sample;
    assign bus.mid_stb      = r_mid;
    assign bus.inc_active   = r_inc;
    assign bus.period_cnt   = w_period_cnt;
    assign bus.period_valid = w_period_valid;

endmodule
`default_nettype wire

// File: tb/tb_dco_nco.sv
`default_nettype none
// ============================================================================
// Module   : tb_dco_nco
// Purpose  : Self-checking bench for dco_nco. Two DUTs (gain shift 2 and 5)
//            share one stimulus stream; a behavioural model predicts every
//            output each cycle, and directed sections pin known values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dco_nco;
    import dco_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       hold;
    logic [7:0] speed;

    always #5 clk = ~clk;

    dco_nco_if #(.ACC_W(16), .CTRL_W(8)) ifa ();
    dco_nco_if #(.ACC_W(16), .CTRL_W(8)) ifb ();

    assign ifa.en        = en;
    assign ifa.hold      = hold;
    assign ifa.speed_var = speed;
    assign ifb.en        = en;
    assign ifb.hold      = hold;
    assign ifb.speed_var = speed;

    dco_nco #(.GAIN_SHIFT(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    dco_nco #(.GAIN_SHIFT(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phase as a plain integer modulo 65536, period
    // length as the number of enabled edges between wraps.
    // ------------------------------------------------------------------
    int m_gs    [2] = '{2, 5};
    int m_ph    [2];
    int m_inc   [2];
    int m_since [2];
    int m_pcnt  [2];
    bit m_s     [2];
    bit m_m     [2];
    bit m_v     [2];
    int m_nxt;

    function automatic int ref_inc(input int spd, input int g);
        int v;
        v = 4096 + (spd - 128) * (1 << g);
        if (v < 2048) v = 2048;
        if (v > 8192) v = 8192;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_ph[k] = 0; m_inc[k] = 4096; m_since[k] = 0; m_pcnt[k] = 0;
                m_s[k] = 1'b0; m_m[k] = 1'b0; m_v[k] = 1'b0;
            end else if (en) begin
                m_nxt = m_ph[k] + m_inc[k];
                m_s[k] = (m_nxt >= 65536);
                m_m[k] = (m_ph[k] < 32768) && (m_nxt >= 32768) && (m_nxt < 65536);
                m_since[k]++;
                m_ph[k] = m_nxt % 65536;
                if (m_s[k]) begin
                    m_pcnt[k]  = (m_since[k] > 255) ? 255 : m_since[k];
                    m_since[k] = 0;
                    m_v[k]     = 1'b1;
                    if (!hold) m_inc[k] = ref_inc(int'(speed), m_gs[k]);
                end
            end else begin
                m_s[k] = 1'b0;
                m_m[k] = 1'b0;
            end
        end
    end

    function automatic logic [43:0] model_vec(input int k);
        logic [15:0] ph;
        logic [15:0] inc;
        logic [7:0]  pc;
        ph  = m_ph[k][15:0];
        inc = m_inc[k][15:0];
        pc  = m_pcnt[k][7:0];
        return {ph, (m_ph[k] >= 32768), m_s[k], m_m[k], inc, pc, m_v[k]};
    endfunction

    // Compare process: every falling edge, whole output vector per DUT.
    logic [43:0] act_a, act_b, exp_a, exp_b;
    always @(negedge clk) begin
        act_a = {ifa.phase, ifa.rclk_out, ifa.sample_stb, ifa.mid_stb,
                 ifa.inc_active, ifa.period_cnt, ifa.period_valid};
        act_b = {ifb.phase, ifb.rclk_out, ifb.sample_stb, ifb.mid_stb,
                 ifb.inc_active, ifb.period_cnt, ifb.period_valid};
        exp_a = model_vec(0);
        exp_b = model_vec(1);
        checks += 2;
        if (act_a !== exp_a) begin
            errors++;
            $display("FAIL cycle_a t=%0t got %h expected %h", $time, act_a, exp_a);
        end
        if (act_b !== exp_b) begin
            errors++;
            $display("FAIL cycle_b t=%0t got %h expected %h", $time, act_b, exp_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until dut_a reports a wrap; n is the number of edges taken.
    task automatic wait_wrap(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ifa.sample_stb && n < 400);
        if (!ifa.sample_stb) begin
            checks++;
            errors++;
            $display("FAIL wrap_timeout got %0d edges expected a wrap", n);
        end
    endtask

    int n, mid_n, highs, r;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; hold = 1'b0; speed = 8'd128;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase",  longint'(ifa.phase), 0);
        chk("rst_inc",    longint'(ifa.inc_active), 4096);
        chk("rst_inc_b",  longint'(ifb.inc_active), 4096);
        chk("rst_pcnt",   longint'(ifa.period_cnt), 0);
        chk("rst_valid",  longint'(ifa.period_valid), 0);
        chk("rst_stb",    longint'({ifa.sample_stb, ifa.mid_stb, ifa.rclk_out}), 0);

        // Nominal rate: 16-edge period, mid strobe after edge 8.
        rst_n = 1'b1; en = 1'b1;
        n = 0; mid_n = 0;
        do begin
            step();
            n++;
            if (ifa.mid_stb && mid_n == 0) mid_n = n;
        end while (!ifa.sample_stb && n < 40);
        chk("first_wrap_edge", n, 16);
        chk("first_mid_edge",  mid_n, 8);
        chk("nominal_pcnt",    longint'(ifa.period_cnt), 16);
        chk("nominal_valid",   longint'(ifa.period_valid), 1);
        highs = 0;
        repeat (16) begin
            step();
            highs += int'(ifa.rclk_out);
        end
        chk("rclk_high_count", highs, 8);
        chk("second_wrap",     longint'(ifa.sample_stb), 1);

        // Speed change mid-period waits for the next wrap.
        repeat (5) step();
        speed = 8'd255;
        repeat (3) step();
        chk("inc_before_wrap", longint'(ifa.inc_active), 4096);
        wait_wrap(n);
        chk("inc_fast_a", longint'(ifa.inc_active), 4604);
        chk("inc_fast_b", longint'(ifb.inc_active), 8160);
        chk("pcnt_last_nominal", longint'(ifa.period_cnt), 16);
        wait_wrap(n);
        chk("pcnt_fast_14_15", longint'(ifa.period_cnt == 8'd14 || ifa.period_cnt == 8'd15), 1);

        // Slow end, and clamp in the high-gain DUT.
        speed = 8'd0;
        wait_wrap(n);
        chk("inc_slow_a", longint'(ifa.inc_active), 3584);
        chk("inc_slow_b", longint'(ifb.inc_active), 2048);
        wait_wrap(n);
        chk("pcnt_slow_18_19", longint'(ifa.period_cnt == 8'd18 || ifa.period_cnt == 8'd19), 1);
        wait_wrap(n);
        chk("pcnt_slow2_18_19", longint'(ifa.period_cnt == 8'd18 || ifa.period_cnt == 8'd19), 1);

        // Hold across a wrap keeps the old increment.
        speed = 8'd128;
        wait_wrap(n);
        chk("inc_back_nominal", longint'(ifa.inc_active), 4096);
        hold = 1'b1; speed = 8'd255;
        wait_wrap(n);
        chk("inc_held", longint'(ifa.inc_active), 4096);
        wait_wrap(n);
        chk("pcnt_held", longint'(ifa.period_cnt), 16);
        hold = 1'b0; speed = 8'd128;

        // Enable low for 5 cycles mid-period.
        repeat (6) step();
        en = 1'b0;
        repeat (5) begin
            step();
            chk("en_low_phase", longint'(ifa.phase), longint'(m_ph[0]));
            chk("en_low_stb", longint'({ifa.sample_stb, ifa.mid_stb}), 0);
        end
        en = 1'b1;
        wait_wrap(n);
        chk("pcnt_with_gap", longint'(ifa.period_cnt), 16);

        // Asynchronous reset mid-period.
        speed = 8'd200;
        wait_wrap(n);
        chk("inc_200", longint'(ifa.inc_active), 4384);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_phase", longint'(ifa.phase), 0);
        chk("arst_inc",   longint'(ifa.inc_active), 4096);
        chk("arst_pcnt",  longint'(ifa.period_cnt), 0);
        chk("arst_valid", longint'(ifa.period_valid), 0);
        chk("arst_rclk",  longint'(ifa.rclk_out), 0);
        step();
        rst_n = 1'b1;
        wait_wrap(n);
        chk("post_rst_period", n, 16);
        chk("post_rst_wrap_b", longint'(ifb.sample_stb), 1);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            step();
            r     = int'($urandom % 100);
            en    = (r >= 15);
            hold  = (($urandom % 10) == 0);
            if (($urandom % 16) == 0) speed = 8'($urandom);
            if (i == 1500 || ($urandom % 900) == 0) begin
                #2;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
